// File: rtl/booth8_pkg.sv
// Shared types and constants for the radix-8 Booth encoder stage.
package booth8_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int LOW_SPLIT     = 17;

    // Groups needed to cover the sign-extended multiplier plus the implicit x[-1].
    function automatic int grp_cnt(input int width);
        return (width >> 2) + 3;
    endfunction

    typedef struct packed {
        logic s;
        logic d;
        logic t;
        logic q;
        logic n;
    } booth_sel_t;

endpackage

// File: rtl/booth8_digit.sv
// One radix-8 Booth group: 4-bit window {x[3i+2], x[3i+1], x[3i], x[3i-1]} to one-hot magnitude plus sign.
module booth8_digit
    import booth8_pkg::*;
(
    input  logic [3:0] win_i,
    output booth_sel_t sel_o
);

    always_comb begin
        sel_o = '0;
        case (win_i)
            4'b0001, 4'b0010: sel_o.s = 1'b1;
            4'b0011, 4'b0100: sel_o.d = 1'b1;
            4'b0101, 4'b0110: sel_o.t = 1'b1;
            4'b0111:          sel_o.q = 1'b1;
            4'b1000: begin sel_o.q = 1'b1; sel_o.n = 1'b1; end
            4'b1001, 4'b1010: begin sel_o.t = 1'b1; sel_o.n = 1'b1; end
            4'b1011, 4'b1100: begin sel_o.d = 1'b1; sel_o.n = 1'b1; end
            4'b1101, 4'b1110: begin sel_o.s = 1'b1; sel_o.n = 1'b1; end
            // 0000 and 1111 are both digit 0: no select, not negative
            default: sel_o = '0;
        endcase
    end

endmodule

// File: rtl/booth8_enc.sv
// Two-stage radix-8 Booth encoder: recodes x into per-group selects and builds 3*y with a split adder.
module booth8_enc
    import booth8_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int GROUP_CNT = grp_cnt(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    output logic [WIDTH-1:0]     my,
    output logic [WIDTH+1:0]     tmy
);

    localparam int XE_W = 3 * GROUP_CNT;
    localparam int HI_W = WIDTH + 2 - LOW_SPLIT;

    logic                        v1_q, v2_q;
    logic                        adv2, ld1, ld2;
    logic signed [WIDTH-1:0]     x_p1_q, y_p1_q;
    logic [LOW_SPLIT-1:0]        tlo_p1_q;
    logic                        cy_p1_q;
    logic [LOW_SPLIT:0]          tlo_sum;
    logic signed [WIDTH+1:0]     ye_p1;
    logic [HI_W-1:0]             thi_p1;
    logic [XE_W:0]               xw_p1;
    booth_sel_t                  sel_p1 [GROUP_CNT];
    logic [GROUP_CNT-1:0]        s_d, d_d, t_d, q_d, n_d;
    logic [GROUP_CNT-1:0]        s_q, d_q, t_q, q_q, n_q;
    logic [WIDTH-1:0]            my_q;
    logic [WIDTH+1:0]            tmy_q;

    assign adv2     = !v2_q || out_ready;
    assign in_ready = !v1_q || adv2;
    assign ld1      = in_valid && in_ready;
    assign ld2      = v1_q && adv2;

    // ---- P0 -> P1: low slice of 3y = (y<<1) + y, carry out of the top low bit kept for P2
    assign tlo_sum = {1'b0, y[LOW_SPLIT-2:0], 1'b0} + {1'b0, y[LOW_SPLIT-1:0]};

    // ---- P1 -> P2: upper slice of 3y from the sign-extended operand and the stored carry
    assign ye_p1  = {{2{y_p1_q[WIDTH-1]}}, y_p1_q};
    assign thi_p1 = ye_p1[WIDTH:LOW_SPLIT-1] + ye_p1[WIDTH+1:LOW_SPLIT]
                  + {{(HI_W-1){1'b0}}, cy_p1_q};

    // Sign-extended multiplier with the implicit zero x[-1] appended as bit 0.
    assign xw_p1 = {{(XE_W-WIDTH){x_p1_q[WIDTH-1]}}, x_p1_q, 1'b0};

    for (genvar gi = 0; gi < GROUP_CNT; gi++) begin : g_grp
        booth8_digit u_digit (
            .win_i (xw_p1[3*gi+3 -: 4]),
            .sel_o (sel_p1[gi])
        );
    end

    always_comb begin
        s_d = '0;
        d_d = '0;
        t_d = '0;
        q_d = '0;
        n_d = '0;
        for (int i = 0; i < GROUP_CNT; i++) begin
            s_d[i] = sel_p1[i].s;
            d_d[i] = sel_p1[i].d;
            t_d[i] = sel_p1[i].t;
            q_d[i] = sel_p1[i].q;
            n_d[i] = sel_p1[i].n;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            x_p1_q   <= '0;
            y_p1_q   <= '0;
            tlo_p1_q <= '0;
            cy_p1_q  <= 1'b0;
            s_q      <= '0;
            d_q      <= '0;
            t_q      <= '0;
            q_q      <= '0;
            n_q      <= '0;
            my_q     <= '0;
            tmy_q    <= '0;
        end else begin
            if (in_ready) v1_q <= in_valid;
            if (adv2)     v2_q <= v1_q;
            if (ld1) begin
                x_p1_q   <= x;
                y_p1_q   <= y;
                tlo_p1_q <= tlo_sum[LOW_SPLIT-1:0];
                cy_p1_q  <= tlo_sum[LOW_SPLIT];
            end
            if (ld2) begin
                s_q   <= s_d;
                d_q   <= d_d;
                t_q   <= t_d;
                q_q   <= q_d;
                n_q   <= n_d;
                my_q  <= y_p1_q;
                tmy_q <= {thi_p1, tlo_p1_q};
            end
        end
    end

    assign out_valid = v2_q;
    assign s         = s_q;
    assign d         = d_q;
    assign t         = t_q;
    assign q         = q_q;
    assign n         = n_q;
    assign my        = my_q;
    assign tmy       = tmy_q;

endmodule
